// File: rtl/core_config_pkg.sv
// Shared machine-mode CSR configuration: addresses, ISA identity and mstatus field positions.
package core_config_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // RV32IM: MXL=1, I and M extension bits set
  localparam logic [31:0] MISA_VALUE = 32'h40001100;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  // Software / timer / external interrupt bit positions in mie and mip
  localparam int IRQ_SW_BIT    = 3;
  localparam int IRQ_TIMER_BIT = 7;
  localparam int IRQ_EXT_BIT   = 11;

  function automatic logic isCsrImplemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access port: one combinational read port, one registered write port, illegal-access flag.
interface csr_file_if;

  logic [11:0] csr_ra;
  logic [31:0] csr_rd;
  logic [11:0] csr_wa;
  logic        csr_we;
  logic [31:0] csr_wd;
  logic        csr_err;

  modport master (output csr_ra, csr_wa, csr_we, csr_wd, input csr_rd, csr_err);
  modport slave  (input csr_ra, csr_wa, csr_we, csr_wd, output csr_rd, csr_err);

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with enable; a write to either half replaces it and skips that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wd,
  output logic [63:0] o_value
);

  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_we_lo) begin
      r_count[31:0] <= i_wd;
    end else if (i_we_hi) begin
      r_count[63:32] <= i_wd;
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_value = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return state, interrupt enables/pending, cycle and instret counters.
module csr_file
  import core_config_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  csr_file_if.slave        csr,
  input  logic             instr_retired,
  input  logic             trap_valid,
  input  logic [31:0]      trap_cause,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      trap_val,
  input  logic             mret_valid,
  input  logic             irq_sw,
  input  logic             irq_timer,
  input  logic             irq_ext,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      mepc_o,
  output logic             irq_take
);

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [2:0]  r_mie;
  logic [2:0]  r_mip;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic        w_wr_illegal;
  logic        w_wr_ok;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie_word;
  logic [31:0] w_mip_word;
  logic [31:0] w_rd;

  // Read-only and ID space (addr[11:10]==2'b11) plus misa/mip reject writes
  assign w_wr_illegal = !isCsrImplemented(csr.csr_wa) || (csr.csr_wa[11:10] == 2'b11) ||
                        (csr.csr_wa == CSR_MISA) || (csr.csr_wa == CSR_MIP);
  assign w_wr_ok      = csr.csr_we && !w_wr_illegal;
  assign csr.csr_err  = csr.csr_we ? w_wr_illegal : !isCsrImplemented(csr.csr_ra);

  // Later assignments win: trap overrides mret, which overrides the CSR write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      r_mip <= {irq_ext, irq_timer, irq_sw};
      if (w_wr_ok) begin
        case (csr.csr_wa)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= csr.csr_wd[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= csr.csr_wd[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      r_mie      <= {csr.csr_wd[IRQ_EXT_BIT], csr.csr_wd[IRQ_TIMER_BIT], csr.csr_wd[IRQ_SW_BIT]};
          CSR_MTVEC:    r_mtvec    <= csr.csr_wd & ~32'h3;
          CSR_MSCRATCH: r_mscratch <= csr.csr_wd;
          CSR_MEPC:     r_mepc     <= csr.csr_wd & ~32'h3;
          CSR_MCAUSE:   r_mcause   <= csr.csr_wd;
          CSR_MTVAL:    r_mtval    <= csr.csr_wd;
          default: ;
        endcase
      end
      if (trap_valid) begin
        r_mepc         <= trap_pc & ~32'h3;
        r_mcause       <= trap_cause;
        r_mtval        <= trap_val;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_valid) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_we_lo (w_wr_ok && (csr.csr_wa == CSR_MCYCLE)),
    .i_we_hi (w_wr_ok && (csr.csr_wa == CSR_MCYCLEH)),
    .i_wd    (csr.csr_wd),
    .o_value (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (instr_retired),
    .i_we_lo (w_wr_ok && (csr.csr_wa == CSR_MINSTRET)),
    .i_we_hi (w_wr_ok && (csr.csr_wa == CSR_MINSTRETH)),
    .i_wd    (csr.csr_wd),
    .o_value (w_minstret)
  );

  always_comb begin
    w_mstatus = '0;
    w_mstatus[MSTATUS_MIE_BIT]      = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT]     = r_mstatus_mpie;
    w_mstatus[MSTATUS_MPP_LO +: 2]  = 2'b11;
    w_mie_word = '0;
    w_mie_word[IRQ_SW_BIT]    = r_mie[0];
    w_mie_word[IRQ_TIMER_BIT] = r_mie[1];
    w_mie_word[IRQ_EXT_BIT]   = r_mie[2];
    w_mip_word = '0;
    w_mip_word[IRQ_SW_BIT]    = r_mip[0];
    w_mip_word[IRQ_TIMER_BIT] = r_mip[1];
    w_mip_word[IRQ_EXT_BIT]   = r_mip[2];
  end

  // ID registers and unimplemented addresses fall through to zero
  always_comb begin
    w_rd = '0;
    case (csr.csr_ra)
      CSR_MSTATUS:                 w_rd = w_mstatus;
      CSR_MISA:                    w_rd = MISA_VALUE;
      CSR_MIE:                     w_rd = w_mie_word;
      CSR_MTVEC:                   w_rd = r_mtvec;
      CSR_MSCRATCH:                w_rd = r_mscratch;
      CSR_MEPC:                    w_rd = r_mepc;
      CSR_MCAUSE:                  w_rd = r_mcause;
      CSR_MTVAL:                   w_rd = r_mtval;
      CSR_MIP:                     w_rd = w_mip_word;
      CSR_MCYCLE,   CSR_CYCLE:     w_rd = w_mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    w_rd = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_rd = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rd = w_minstret[63:32];
      default:                     w_rd = '0;
    endcase
  end

  assign csr.csr_rd = w_rd;
  assign mtvec_o    = r_mtvec;
  assign mepc_o     = r_mepc;
  assign irq_take   = r_mstatus_mie & |(r_mie & r_mip);

endmodule

// File: tb/tb_csr_file.sv
// Directed-vector bench for csr_file: stimulus queues expected values, a negedge monitor compares them.
module tb_csr_file;

  typedef enum int {K_RD, K_ERR, K_IRQ, K_MTVEC, K_MEPC} chkKind_t;

  typedef struct {
    string       name;
    chkKind_t    kind;
    logic [31:0] exp;
  } sbItem_t;

  logic        clk;
  logic        rst;
  logic        instr_retired;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_valid;
  logic        irq_sw;
  logic        irq_timer;
  logic        irq_ext;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_take;

  int compared   = 0;
  int mismatched = 0;
  sbItem_t sbQueue[$];

  csr_file_if bus ();

  csr_file dut (
    .clk           (clk),
    .rst           (rst),
    .csr           (bus),
    .instr_retired (instr_retired),
    .trap_valid    (trap_valid),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_val      (trap_val),
    .mret_valid    (mret_valid),
    .irq_sw        (irq_sw),
    .irq_timer     (irq_timer),
    .irq_ext       (irq_ext),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o),
    .irq_take      (irq_take)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                               input logic [11:0] ra);
    bus.csr_we = we;
    bus.csr_wa = wa;
    bus.csr_wd = wd;
    bus.csr_ra = ra;
  endtask

  task automatic expectOut(input string name, input chkKind_t kind, input logic [31:0] exp);
    sbItem_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    sbQueue.push_back(it);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input sbItem_t it);
    logic [31:0] act;
    case (it.kind)
      K_RD:    act = bus.csr_rd;
      K_ERR:   act = {31'b0, bus.csr_err};
      K_IRQ:   act = {31'b0, irq_take};
      K_MTVEC: act = mtvec_o;
      default: act = mepc_o;
    endcase
    compared++;
    if (act !== it.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
    end
  endtask

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    instr_retired = 1'b0;
    trap_valid = 1'b0;
    trap_cause = '0;
    trap_pc = '0;
    trap_val = '0;
    mret_valid = 1'b0;
    irq_sw = 1'b0;
    irq_timer = 1'b0;
    irq_ext = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB00);
    repeat (10) stepClk();
    rst = 1'b0;

    // reset state
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB00);
    expectOut("reset mcycle", K_RD, 32'h0);
    expectOut("reset err", K_ERR, 32'h0);
    expectOut("reset irq_take", K_IRQ, 32'h0);
    expectOut("reset mtvec_o", K_MTVEC, 32'h0);
    expectOut("reset mepc_o", K_MEPC, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("reset mstatus", K_RD, 32'h0000_1800);
    repeat (9) stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB00);
    expectOut("mcycle after 10 edges", K_RD, 32'd10);
    expectOut("mcycle read err", K_ERR, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB80);
    expectOut("mcycleh after reset", K_RD, 32'h0);
    stepClk();

    // unimplemented read, misa, ID register
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h7C0);
    expectOut("unimpl read data", K_RD, 32'h0);
    expectOut("unimpl read err", K_ERR, 32'h1);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h301);
    expectOut("misa value", K_RD, 32'h4000_1100);
    expectOut("misa read err", K_ERR, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hF14);
    expectOut("mhartid value", K_RD, 32'h0);
    expectOut("mhartid read err", K_ERR, 32'h0);
    stepClk();

    // mtvec write, same-cycle old value, low bits forced zero
    applyStimulus(1'b1, 12'h305, 32'h0000_1003, 12'h305);
    expectOut("mtvec same-cycle old", K_RD, 32'h0);
    expectOut("mtvec write err", K_ERR, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h305);
    expectOut("mtvec read", K_RD, 32'h0000_1000);
    expectOut("mtvec_o", K_MTVEC, 32'h0000_1000);
    stepClk();
    applyStimulus(1'b1, 12'h301, 32'hFFFF_FFFF, 12'h301);
    expectOut("misa write err", K_ERR, 32'h1);
    stepClk();
    applyStimulus(1'b1, 12'h344, 32'hFFFF_FFFF, 12'h344);
    expectOut("mip write err", K_ERR, 32'h1);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h301);
    expectOut("misa after rejected write", K_RD, 32'h4000_1100);
    stepClk();

    // mcycle 64-bit wrap
    applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFF, 12'hB00);
    expectOut("mcycle write err", K_ERR, 32'h0);
    stepClk();
    applyStimulus(1'b1, 12'hB80, 32'hFFFF_FFFF, 12'hB00);
    expectOut("mcycle lo after write", K_RD, 32'hFFFF_FFFF);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB80);
    expectOut("mcycleh after write", K_RD, 32'hFFFF_FFFF);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB00);
    expectOut("mcycle wrap lo", K_RD, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB80);
    expectOut("mcycle wrap hi", K_RD, 32'h0);
    stepClk();

    // carry into high half
    applyStimulus(1'b1, 12'hB00, 32'hFFFF_FFFF, 12'hB00);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB80);
    expectOut("mcycleh before carry", K_RD, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB80);
    expectOut("mcycleh after carry", K_RD, 32'h1);
    stepClk();
    applyStimulus(1'b1, 12'hC00, 32'h0000_0055, 12'hB00);
    expectOut("cycle write err", K_ERR, 32'h1);
    expectOut("mcycle before rejected write", K_RD, 32'h1);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hC00);
    expectOut("cycle alias after rejected write", K_RD, 32'h2);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hC80);
    expectOut("cycleh alias", K_RD, 32'h1);
    stepClk();

    // minstret
    instr_retired = 1'b1;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB02);
    expectOut("minstret reset", K_RD, 32'h0);
    stepClk();
    stepClk();
    applyStimulus(1'b1, 12'hB02, 32'd100, 12'hB02);
    expectOut("minstret count", K_RD, 32'h2);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB02);
    expectOut("minstret write suppresses inc", K_RD, 32'd100);
    stepClk();
    instr_retired = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hC02);
    expectOut("instret alias", K_RD, 32'd101);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB82);
    expectOut("minstreth", K_RD, 32'h0);
    stepClk();

    // interrupt enable, pending, trap entry
    applyStimulus(1'b1, 12'h300, 32'h0000_0008, 12'h300);
    stepClk();
    applyStimulus(1'b1, 12'h304, 32'hFFFF_FFFF, 12'h300);
    expectOut("mstatus MIE set", K_RD, 32'h0000_1808);
    stepClk();
    irq_timer = 1'b1;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h304);
    expectOut("mie mask", K_RD, 32'h0000_0888);
    expectOut("irq_take before mip", K_IRQ, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h344);
    expectOut("mip timer", K_RD, 32'h0000_0080);
    expectOut("irq_take timer", K_IRQ, 32'h1);
    trap_valid = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc = 32'h0000_0104;
    trap_val = 32'hDEAD_BEEF;
    stepClk();
    trap_valid = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("mstatus after trap", K_RD, 32'h0000_1880);
    expectOut("mepc_o after trap", K_MEPC, 32'h0000_0104);
    expectOut("irq_take after trap", K_IRQ, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h342);
    expectOut("mcause", K_RD, 32'h8000_0007);
    stepClk();
    irq_timer = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h343);
    expectOut("mtval", K_RD, 32'hDEAD_BEEF);
    stepClk();
    mret_valid = 1'b1;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h341);
    expectOut("mepc read", K_RD, 32'h0000_0104);
    stepClk();
    mret_valid = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("mstatus after mret", K_RD, 32'h0000_1888);
    stepClk();

    // trap beats mepc write, mret beats mstatus write
    trap_valid = 1'b1;
    trap_cause = 32'h0000_0002;
    trap_pc = 32'h0000_0202;
    trap_val = 32'h0;
    applyStimulus(1'b1, 12'h341, 32'h0000_3000, 12'h000);
    stepClk();
    trap_valid = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("mstatus after second trap", K_RD, 32'h0000_1880);
    expectOut("mepc trap beats write", K_MEPC, 32'h0000_0200);
    stepClk();
    mret_valid = 1'b1;
    applyStimulus(1'b1, 12'h300, 32'h0, 12'h000);
    stepClk();
    mret_valid = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("mstatus mret beats write", K_RD, 32'h0000_1888);
    stepClk();

    // plain mepc / mscratch writes, external interrupt
    applyStimulus(1'b1, 12'h341, 32'h0000_0123, 12'h000);
    stepClk();
    applyStimulus(1'b1, 12'h340, 32'hA5A5_A5A5, 12'h341);
    expectOut("mepc write masked", K_RD, 32'h0000_0120);
    expectOut("mepc_o write masked", K_MEPC, 32'h0000_0120);
    stepClk();
    irq_ext = 1'b1;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h340);
    expectOut("mscratch", K_RD, 32'hA5A5_A5A5);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h344);
    expectOut("mip ext", K_RD, 32'h0000_0800);
    expectOut("irq_take ext", K_IRQ, 32'h1);
    stepClk();

    // reset overrides a concurrent write and trap
    rst = 1'b1;
    irq_ext = 1'b0;
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0040;
    applyStimulus(1'b1, 12'h340, 32'h0000_1234, 12'h000);
    stepClk();
    rst = 1'b0;
    trap_valid = 1'b0;
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h340);
    expectOut("mscratch after reset", K_RD, 32'h0);
    expectOut("mepc_o after reset", K_MEPC, 32'h0);
    expectOut("mtvec_o after reset", K_MTVEC, 32'h0);
    expectOut("irq_take after reset", K_IRQ, 32'h0);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'h300);
    expectOut("mstatus after reset", K_RD, 32'h0000_1800);
    stepClk();
    applyStimulus(1'b0, 12'h000, 32'h0, 12'hB00);
    expectOut("mcycle after reset", K_RD, 32'h2);

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && sbQueue.size() > 0; i++) @(negedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQueue.size());
      mismatched += sbQueue.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
